soc_sysinfo: RTL and testbench
==============================

SOC_SYSINFO -- requirements
Module: soc_sysinfo

Interface
REQ-001 Parameter SYSTEM_ID, default 32'h0000_0000, value returned at register 0.
REQ-002 Parameter TIMESTAMP, default 32'd1668672546, value returned at register 1.
REQ-003 Parameter ADDR_W, default 4, word-address width; legal range 4..8.
REQ-004 Parameter READ_LATENCY, default 1, read-accept to readdatavalid cycles; legal range 1..3.
REQ-005 Parameter NUM_SCRATCH, default 4, scratch register count at word addresses 8..8+NUM_SCRATCH-1; legal range 0..8.
REQ-006 clock  input  1  single clock; all state on rising edge.
REQ-007 reset_n  input  1  reset, synchronous, active-low.
REQ-008 address  input  ADDR_W  word address.
REQ-009 read  input  1  read request, accepted every cycle asserted.
REQ-010 write  input  1  write request, accepted every cycle asserted.
REQ-011 writedata  input  32  write data.
REQ-012 byteenable  input  4  per-byte write enable.
REQ-013 readdata  output  32  read data, valid only with readdatavalid.
REQ-014 readdatavalid  output  1  one-cycle pulse per accepted read.

Function
REQ-015 Register map SHALL be: 0 SYSTEM_ID (RO), 1 TIMESTAMP (RO), 2 UPTIME_LO (RO, write clears counter), 3 UPTIME_HI (RO, snapshot), 4 SCRATCH_COUNT (RO, =NUM_SCRATCH), 8.. scratch (RW); all other addresses read 0, writes ignored.
REQ-016 No waitrequest; module SHALL accept one read or write per cycle, fully pipelined.
REQ-017 Read accepted in cycle N SHALL produce readdatavalid=1 with its data in cycle N+READ_LATENCY; reads return in order.
REQ-018 readdata SHALL be 0 whenever readdatavalid is 0.
REQ-019 64-bit uptime counter SHALL increment by 1 every cycle, wrapping 2^64-1 -> 0.
REQ-020 Read of UPTIME_LO SHALL return counter[31:0] as of the accept cycle and latch counter[63:32] of that same cycle into the HI snapshot.
REQ-021 Read of UPTIME_HI SHALL return the snapshot, unchanged until the next UPTIME_LO read.
REQ-022 Write to UPTIME_LO, any data, SHALL set counter to 0 in the next cycle, then counting resumes; snapshot is unaffected.
REQ-023 Scratch writes SHALL update only bytes with byteenable set; byteenable 0000 is a no-op.
REQ-024 read and write asserted in the same cycle SHALL both be accepted; the read returns the pre-write value.

Reset
REQ-025 While reset_n=0 at a clock edge: readdatavalid=0, readdata=0, counter=0, snapshot=0, scratch=0.
REQ-026 Reads in flight when reset asserts SHALL be discarded; no readdatavalid after reset for them.
REQ-027 Requests presented while reset_n=0 SHALL be ignored.

Configuration
REQ-028 Macro SOC_SYSINFO_UPTIME_EN defined: counter and snapshot present per REQ-019..022.
REQ-029 Macro undefined: no counter/snapshot logic; addresses 2 and 3 read 0, writes ignored; all else unchanged.

Structure
REQ-030 Package soc_sysinfo_pkg SHALL hold register offset constants (REG_ID, REG_TS, REG_UP_LO, REG_UP_HI, REG_SCNT, REG_SCR_BASE) and parameter limit constants.
REQ-031 Sub-module soc_sysinfo_rdpipe SHALL implement the READ_LATENCY-deep valid/data pipeline with synchronous clear.

Verification
REQ-032 Reset, read addr 0 and 1 (defaults) -> readdatavalid after READ_LATENCY, data 0 then 1668672546.
REQ-033 READ_LATENCY=3, back-to-back reads addr 4,0,4 -> three consecutive valid cycles, data 4,0,4.
REQ-034 Write 32'hDEADBEEF to addr 8 be=1111, then 32'h00000011 be=0001, read -> 32'hDEADBE11.
REQ-035 UPTIME_EN, force counter 32'hFFFF_FFFF low/0 high, read LO then HI -> HI snapshot consistent with LO (no torn value); write addr 2 -> subsequent LO read < 16.
REQ-036 Assert reset_n=0 one cycle after read accepted -> no readdatavalid; scratch reads 0 afterward.
REQ-037 UPTIME_EN undefined: read addr 2 and 3 -> 0; write addr 2 -> no effect.

Source files
------------

// File: rtl/soc_sysinfo_pkg.sv
// Shared register offsets, parameter limits and byte-merge helper for soc_sysinfo.
package soc_sysinfo_pkg;

  localparam int unsigned REG_ID       = 0;
  localparam int unsigned REG_TS       = 1;
  localparam int unsigned REG_UP_LO    = 2;
  localparam int unsigned REG_UP_HI    = 3;
  localparam int unsigned REG_SCNT     = 4;
  localparam int unsigned REG_SCR_BASE = 8;

  localparam int unsigned ADDR_W_MIN      = 4;
  localparam int unsigned ADDR_W_MAX      = 8;
  localparam int unsigned RD_LAT_MIN      = 1;
  localparam int unsigned RD_LAT_MAX      = 3;
  localparam int unsigned NUM_SCRATCH_MAX = 8;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/soc_sysinfo_rdpipe.sv
// Fixed-depth read-return pipeline; data is forced to zero on non-valid beats.
module soc_sysinfo_rdpipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        out_valid,
  output logic [31:0] out_data
);

  logic [DEPTH-1:0]       vld_q;
  logic [DEPTH-1:0][31:0] dat_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      dat_q[0] <= in_valid ? in_data : 32'h0;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/soc_sysinfo.sv
// System information register block: IDs, scratch registers and an optional 64-bit uptime
// counter with HI snapshot (enabled by defining SOC_SYSINFO_UPTIME_EN).
module soc_sysinfo
  import soc_sysinfo_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'd1668672546,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned NUM_SCRATCH  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  // Out-of-range parameters are clamped to the supported limits.
  localparam int unsigned LAT  = (READ_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                                 (READ_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : READ_LATENCY;
  localparam int unsigned NSCR = (NUM_SCRATCH > NUM_SCRATCH_MAX) ? NUM_SCRATCH_MAX
                                                                 : NUM_SCRATCH;

  logic [31:0] addr_w;
  logic        scr_hit;
  logic [2:0]  scr_idx;
  logic [31:0] rd_data;

  assign addr_w  = 32'(address);
  assign scr_hit = (addr_w >= REG_SCR_BASE) && (addr_w < REG_SCR_BASE + NSCR);
  assign scr_idx = 3'(addr_w - REG_SCR_BASE);

  logic [NUM_SCRATCH_MAX-1:0][31:0] scr_q, scr_d;

  always_comb begin
    scr_d = scr_q;
    if (write && scr_hit) begin
      scr_d[scr_idx] = merge_bytes(scr_q[scr_idx], writedata, byteenable);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      scr_q <= '0;
    end else begin
      scr_q <= scr_d;
    end
  end

`ifdef SOC_SYSINFO_UPTIME_EN
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;

  always_comb begin
    cnt_d  = (write && addr_w == REG_UP_LO) ? 64'h0 : cnt_q + 64'd1;
    // Snapshot the upper half in the same cycle the lower half is sampled.
    snap_d = (read && addr_w == REG_UP_LO) ? cnt_q[63:32] : snap_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
    end
  end
`endif

  // Read value is taken from current state, so a same-cycle write is not yet visible.
  always_comb begin
    rd_data = 32'h0;
    case (addr_w)
      REG_ID:    rd_data = SYSTEM_ID;
      REG_TS:    rd_data = TIMESTAMP;
`ifdef SOC_SYSINFO_UPTIME_EN
      REG_UP_LO: rd_data = cnt_q[31:0];
      REG_UP_HI: rd_data = snap_q;
`endif
      REG_SCNT:  rd_data = 32'(NSCR);
      default: begin
        if (scr_hit) rd_data = scr_q[scr_idx];
      end
    endcase
  end

  soc_sysinfo_rdpipe #(
    .DEPTH(LAT)
  ) u_rdpipe (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (read),
    .in_data  (rd_data),
    .out_valid(readdatavalid),
    .out_data (readdata)
  );

endmodule

// File: tb/tb_soc_sysinfo.sv
// Randomized self-checking bench for soc_sysinfo against a register-map reference model.
module tb_soc_sysinfo;

  localparam int unsigned LAT = 3;
`ifdef SOC_SYSINFO_UPTIME_EN
  localparam bit UP = 1'b1;
`else
  localparam bit UP = 1'b0;
`endif
  localparam logic [31:0] ID_VAL = 32'h0000_0000;
  localparam logic [31:0] TS_VAL = 32'd1668672546;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  always #5 clock = ~clock;

  soc_sysinfo #(
    .READ_LATENCY(LAT)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .readdata     (readdata),
    .readdatavalid(readdatavalid)
  );

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state: register contents by address, uptime as a plain count.
  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } pend_t;

  logic [31:0]     m_scr [16];
  longint unsigned m_cnt;
  logic [31:0]     m_snap;
  int unsigned     cyc = 0;
  pend_t           pq[$];

  function automatic logic [31:0] model_read(input int unsigned a);
    if (a == 0) return ID_VAL;
    if (a == 1) return TS_VAL;
    if (a == 2) return UP ? m_cnt[31:0] : 32'h0;
    if (a == 3) return UP ? m_snap : 32'h0;
    if (a == 4) return 32'd4;
    if (a >= 8 && a <= 11) return m_scr[a];
    return 32'h0;
  endfunction

  task automatic step(input logic rd, input logic wr, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] be, input logic rst);
    pend_t p;
    int unsigned ai;
    ai = int'(a);
    reset_n    = ~rst;
    read       = rd;
    write      = wr;
    address    = a;
    writedata  = d;
    byteenable = be;
    if (rst) begin
      pq.delete();
      for (int i = 0; i < 16; i++) m_scr[i] = '0;
      m_cnt  = 0;
      m_snap = '0;
    end else begin
      if (rd) begin
        p.due  = cyc + LAT;
        p.data = model_read(ai);
        pq.push_back(p);
        if (ai == 2) m_snap = m_cnt[63:32];
      end
      if (wr && ai >= 8 && ai <= 11) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) m_scr[ai][8*b +: 8] = d[8*b +: 8];
        end
      end
      m_cnt = (UP && wr && ai == 2) ? 0 : m_cnt + 1;
    end
    @(posedge clock);
    #1;
    cyc++;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      check_eq("rdvalid", {31'h0, readdatavalid}, 32'h1);
      check_eq("rddata", readdata, pq[0].data);
      void'(pq.pop_front());
    end else begin
      check_eq("rdvalid_idle", {31'h0, readdatavalid}, 32'h0);
      check_eq("rddata_idle", readdata, 32'h0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_scr[i] = '0;
    m_cnt  = 0;
    m_snap = '0;

    step(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1);
    step(1'b1, 1'b1, 4'd8, 32'hFFFF_FFFF, 4'hF, 1'b1);
    idle(2);

    // Identity registers, then back-to-back reads 4,0,4.
    step(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 4'd1, 32'h0, 4'h0, 1'b0);
    idle(LAT);
    step(1'b1, 1'b0, 4'd4, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 4'd4, 32'h0, 4'h0, 1'b0);
    idle(LAT);

    // Byte-enable merge, empty byteenable, and read-with-write returning old value.
    step(1'b0, 1'b1, 4'd8, 32'hDEAD_BEEF, 4'hF, 1'b0);
    step(1'b0, 1'b1, 4'd8, 32'h0000_0011, 4'h1, 1'b0);
    step(1'b0, 1'b1, 4'd8, 32'h1234_5678, 4'h0, 1'b0);
    step(1'b1, 1'b1, 4'd8, 32'hA5A5_A5A5, 4'hC, 1'b0);
    step(1'b1, 1'b0, 4'd8, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 4'd11, 32'hCAFE_F00D, 4'hF, 1'b0);
    step(1'b1, 1'b0, 4'd11, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 4'd12, 32'h1111_1111, 4'hF, 1'b0);
    idle(LAT);

    // Uptime: clear, read LO then HI, read again after some cycles.
    idle(5);
    step(1'b0, 1'b1, 4'd2, 32'h5555_5555, 4'hF, 1'b0);
    step(1'b1, 1'b0, 4'd2, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 4'd3, 32'h0, 4'h0, 1'b0);
    idle(7);
    step(1'b1, 1'b1, 4'd2, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 4'd2, 32'h0, 4'h0, 1'b0);
    idle(LAT);

    // Reset one cycle after a read is accepted: the read must vanish, scratch must clear.
    step(1'b1, 1'b0, 4'd9, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 4'd9, 32'h7777_7777, 4'hF, 1'b1);
    idle(LAT + 1);
    step(1'b1, 1'b0, 4'd8, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 4'd2, 32'h0, 4'h0, 1'b0);
    idle(LAT);

    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
           $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 59) == 0));
    end
    idle(LAT + 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
